cmd_word_assembler: RTL and testbench

//  Parametrised byte-stream-to-command-word assembler with output FIFO. Sits between the

---
 rtl/cmd_word_assembler.sv | 177 +++++++++++++++++
 tb/tb_cmd_word_assembler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_word_assembler.sv
// Byte-stream to command-word assembler with an output FIFO and inter-byte timeout resync.
// Optional per-frame checksum byte verification: define CMD_ASM_CHKSUM_EN.
module cmd_word_assembler #(
    parameter int unsigned WORD_W      = 16,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned TIMEOUT_CYC = 1000,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic                     rx_ready,
    output logic [WORD_W-1:0]        word_out,
    output logic                     word_valid,
    input  logic                     word_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     sync_err,
    output logic [CNT_W-1:0]         err_cnt
);

    localparam int unsigned NB = WORD_W / 8;
`ifdef CMD_ASM_CHKSUM_EN
    localparam int unsigned FL = NB + 1;
`else
    localparam int unsigned FL = NB;
`endif
    localparam int unsigned IDX_W  = (FL > 1) ? $clog2(FL) : 1;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned LVL_W  = PTR_W + 1;
    localparam int unsigned IDLE_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] sh_q, sh_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  lvl_q, lvl_d;
    logic [WORD_W-1:0] word_out_q, word_out_d;
    logic              word_valid_q, word_valid_d;
    logic              rx_ready_q, rx_ready_d;
    logic              sync_err_q, sync_err_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
`ifdef CMD_ASM_CHKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    logic              accept;
    logic              pop;
    logic              timeout;
    logic              push;
    logic [WORD_W-1:0] push_word;

    // Frame assembly, timeout resync, FIFO bookkeeping and next-cycle output values
    always_comb begin
        idx_d      = idx_q;
        sh_d       = sh_q;
        idle_d     = idle_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        sync_err_d = 1'b0;
        err_cnt_d  = err_cnt_q;
        push       = 1'b0;
        push_word  = '0;
`ifdef CMD_ASM_CHKSUM_EN
        sum_d      = sum_q;
`endif

        accept  = rx_valid & rx_ready_q;
        pop     = word_valid_q & word_ready;
        timeout = (TIMEOUT_CYC != 0) && (idx_q != '0) && (idle_q == IDLE_W'(TIMEOUT_CYC));

        if (timeout) begin
            idx_d      = '0;
            sh_d       = '0;
            idle_d     = '0;
            sync_err_d = 1'b1;
`ifdef CMD_ASM_CHKSUM_EN
            sum_d      = '0;
`endif
        end else if (idx_q == '0) begin
            idle_d = '0;
        end else if (!accept) begin
            idle_d = idle_q + IDLE_W'(1);
        end

        // A byte taken in the timeout cycle starts a fresh frame, hence idx_d/sh_d here
        if (accept) begin
            idle_d = '0;
            if (idx_d == IDX_W'(FL - 1)) begin
                idx_d = '0;
`ifdef CMD_ASM_CHKSUM_EN
                if (rx_data == sum_d) begin
                    push      = 1'b1;
                    push_word = sh_d;
                end else if (err_cnt_q != {CNT_W{1'b1}}) begin
                    err_cnt_d = err_cnt_q + CNT_W'(1);
                end
                sum_d = '0;
`else
                push      = 1'b1;
                push_word = (sh_d << 8) | WORD_W'(rx_data);
`endif
                sh_d  = '0;
            end else begin
                idx_d = idx_d + IDX_W'(1);
                sh_d  = (sh_d << 8) | WORD_W'(rx_data);
`ifdef CMD_ASM_CHKSUM_EN
                sum_d = sum_d + rx_data;
`endif
            end
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push) begin
            mem_d[wr_ptr_q] = push_word;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        lvl_d = lvl_q + LVL_W'(push) - LVL_W'(pop);

        word_valid_d = (lvl_d != '0);
        word_out_d   = word_valid_d ? mem_d[rd_ptr_d] : '0;
        // Only the frame-closing byte needs FIFO space
        rx_ready_d   = !((idx_d == IDX_W'(FL - 1)) && (lvl_d == LVL_W'(DEPTH)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q        <= '0;
            sh_q         <= '0;
            idle_q       <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            lvl_q        <= '0;
            word_out_q   <= '0;
            word_valid_q <= 1'b0;
            rx_ready_q   <= 1'b1;
            sync_err_q   <= 1'b0;
            err_cnt_q    <= '0;
`ifdef CMD_ASM_CHKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            idx_q        <= idx_d;
            sh_q         <= sh_d;
            idle_q       <= idle_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            lvl_q        <= lvl_d;
            word_out_q   <= word_out_d;
            word_valid_q <= word_valid_d;
            rx_ready_q   <= rx_ready_d;
            sync_err_q   <= sync_err_d;
            err_cnt_q    <= err_cnt_d;
`ifdef CMD_ASM_CHKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    assign rx_ready   = rx_ready_q;
    assign word_out   = word_out_q;
    assign word_valid = word_valid_q;
    assign fifo_level = lvl_q;
    assign sync_err   = sync_err_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_cmd_word_assembler.sv
// Bench for cmd_word_assembler: queue-based frame/FIFO model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_cmd_word_assembler;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned TMO    = 20;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned NB     = WORD_W / 8;
`ifdef CMD_ASM_CHKSUM_EN
    localparam int unsigned FL = NB + 1;
`else
    localparam int unsigned FL = NB;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic [7:0]             rx_data;
    logic                   rx_valid;
    logic                   rx_ready;
    logic [WORD_W-1:0]      word_out;
    logic                   word_valid;
    logic                   word_ready;
    logic [$clog2(DEPTH):0] fifo_level;
    logic                   sync_err;
    logic [CNT_W-1:0]       err_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Model state: bytes of the frame in progress, stored words, idle cycles mid-frame
    int unsigned       part[$];
    logic [WORD_W-1:0] mq[$];
    int                idle  = 0;
    int                m_err = 0;
    bit                m_sync = 1'b0;

    always #5 clk = ~clk;

    cmd_word_assembler #(
        .WORD_W(WORD_W), .DEPTH(DEPTH), .TIMEOUT_CYC(TMO), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
        .fifo_level(fifo_level), .sync_err(sync_err), .err_cnt(err_cnt)
    );

    function automatic logic [7:0] csum(input logic [WORD_W-1:0] w);
        logic [7:0] s = 8'h00;
        for (int i = 0; i < int'(NB); i++) s = s + w[8*i +: 8];
        return s;
    endfunction

    function automatic logic [7:0] frame_byte(input logic [WORD_W-1:0] w, input int i);
        if (i < int'(NB)) return w[WORD_W-1-8*i -: 8];
        return csum(w);
    endfunction

    function automatic bit m_ready();
        return !((part.size() == int'(FL) - 1) && (mq.size() == int'(DEPTH)));
    endfunction

    function automatic logic [WORD_W-1:0] part_word();
        logic [WORD_W-1:0] w = '0;
        for (int i = 0; i < int'(NB) && i < part.size(); i++) w = (w << 8) | WORD_W'(part[i]);
        return w;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: dut=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("rx_ready", 64'(rx_ready), 64'(m_ready()));
        check("word_valid", 64'(word_valid), 64'(mq.size() != 0));
        check("fifo_level", 64'(fifo_level), 64'(mq.size()));
        check("sync_err", 64'(sync_err), 64'(m_sync));
        check("err_cnt", 64'(err_cnt), 64'(m_err));
        if (mq.size() != 0) check("word_out", 64'(word_out), 64'(mq[0]));
    endtask

    task automatic model_reset();
        part.delete();
        mq.delete();
        idle   = 0;
        m_err  = 0;
        m_sync = 1'b0;
    endtask

    // One clock edge of the reference behaviour, given this cycle's inputs
    task automatic model_step(input bit v, input logic [7:0] d, input bit wr);
        bit acc = v && m_ready();
        bit pop = (mq.size() != 0) && wr;
        bit tmo = (part.size() != 0) && (idle == int'(TMO));
        logic [WORD_W-1:0] w;
        m_sync = tmo;
        if (pop) void'(mq.pop_front());
        if (tmo) begin
            part.delete();
            idle = 0;
        end
        if (acc) begin
            idle = 0;
            part.push_back(int'(d));
            if (part.size() == int'(FL)) begin
                w = part_word();
`ifdef CMD_ASM_CHKSUM_EN
                if (csum(w) == 8'(part[NB])) mq.push_back(w);
                else if (m_err < (1 << CNT_W) - 1) m_err++;
`else
                mq.push_back(w);
`endif
                part.delete();
            end
        end else if (!tmo) begin
            if (part.size() == 0) idle = 0;
            else idle++;
        end
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit wr);
        rx_valid   = v;
        rx_data    = d;
        word_ready = wr;
        model_step(v, d, wr);
        @(negedge clk);
        compare_all();
    endtask

    task automatic send_word(input logic [WORD_W-1:0] w, input bit wr_last);
        for (int i = 0; i < int'(FL); i++)
            step(1'b1, frame_byte(w, i), (i == int'(FL) - 1) ? wr_last : 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * int'(DEPTH) && mq.size() != 0; i++) step(1'b0, 8'h00, 1'b1);
        check("drained", 64'(word_valid), 64'(0));
    endtask

    initial begin
        int pulses;
        int pv;
        int pr;
        rst        = 1'b0;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
        word_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst = 1'b1;
        step(1'b0, 8'h00, 1'b0);

        // Basic assembly, MSB first
        send_word(16'hABCD, 1'b0);
        check("t1_word", 64'(word_out), 64'h ABCD);
        check("t1_valid", 64'(word_valid), 64'(1));
        check("t1_level", 64'(fifo_level), 64'(1));
        drain();

        // Fill the FIFO, then backpressure on the frame-closing byte
        for (int k = 0; k < int'(DEPTH); k++) send_word(WORD_W'(16'h1000 + k), 1'b0);
        check("t2_full", 64'(fifo_level), 64'(DEPTH));
        for (int i = 0; i < int'(FL) - 1; i++) step(1'b1, frame_byte(16'h5566, i), 1'b0);
        check("t2_blocked", 64'(rx_ready), 64'(0));
        step(1'b1, frame_byte(16'h5566, int'(FL) - 1), 1'b1);
        check("t2_popped", 64'(fifo_level), 64'(DEPTH - 1));
        step(1'b1, frame_byte(16'h5566, int'(FL) - 1), 1'b0);
        check("t2_refill", 64'(fifo_level), 64'(DEPTH));
        drain();

        // Timeout discards the partial frame
        step(1'b1, 8'h12, 1'b0);
        pulses = 0;
        repeat (TMO + 5) begin
            step(1'b0, 8'h00, 1'b0);
            pulses += int'(sync_err);
        end
        check("t3_pulses", 64'(pulses), 64'(1));
        check("t3_nopush", 64'(fifo_level), 64'(0));
        send_word(16'h3456, 1'b0);
        check("t3_word", 64'(word_out), 64'h3456);

        // Asynchronous reset mid-frame
        step(1'b1, 8'h11, 1'b0);
        #2;
        rst      = 1'b0;
        rx_valid = 1'b0;
        #1;
        check("t4_rst_valid", 64'(word_valid), 64'(0));
        check("t4_rst_level", 64'(fifo_level), 64'(0));
        check("t4_rst_word", 64'(word_out), 64'(0));
        check("t4_rst_ready", 64'(rx_ready), 64'(1));
        check("t4_rst_sync", 64'(sync_err), 64'(0));
        check("t4_rst_err", 64'(err_cnt), 64'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        compare_all();
        send_word(16'h2233, 1'b0);
        check("t4_word", 64'(word_out), 64'h2233);
        check("t4_level", 64'(fifo_level), 64'(1));

        // Push and pop on the same edge
        send_word(16'h7788, 1'b1);
        check("t5_level", 64'(fifo_level), 64'(1));
        check("t5_word", 64'(word_out), 64'h7788);
        drain();

`ifdef CMD_ASM_CHKSUM_EN
        send_word(16'h0102, 1'b0);
        check("t6_good", 64'(word_out), 64'h0102);
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h02, 1'b0);
        step(1'b1, 8'h04, 1'b0);
        check("t6_errcnt", 64'(err_cnt), 64'(1));
        check("t6_nopush", 64'(fifo_level), 64'(1));
        drain();
`endif

        // Randomized traffic with varying valid/ready densities
        pv = 50;
        pr = 50;
        for (int c = 0; c < 4000; c++) begin
            bit         v;
            bit         wr;
            logic [7:0] d;
            if (c % 250 == 0) begin
                pv = $urandom_range(3, 95);
                pr = $urandom_range(5, 95);
            end
            v  = ($urandom_range(0, 99) < pv);
            wr = ($urandom_range(0, 99) < pr);
            d  = 8'($urandom);
`ifdef CMD_ASM_CHKSUM_EN
            if (part.size() == int'(NB) && $urandom_range(0, 3) != 0) d = csum(part_word());
`endif
            step(v, d, wr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
